// File: rtl/decode_queue.sv
// decode_queue: instruction FIFO feeding a registered RV32I(+M) decode stage.
// The FIFO head is decoded combinationally, so the output register always loads finished fields.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic                   clk_In,
    input  logic                   rst_In,
    input  logic                   flush_In,
    input  logic                   instrValid_In,
    input  logic [31:0]            instr_In,
    input  logic [31:0]            pc_In,
    output logic                   instrReady_Out,
    output logic                   decValid_Out,
    input  logic                   decReady_In,
    output logic [31:0]            pc_Out,
    output logic [2:0]             instrType_Out,
    output logic [2:0]             funct3_Out,
    output logic [4:0]             rdAddr_Out,
    output logic [4:0]             rs1Addr_Out,
    output logic                   rs1Enable_Out,
    output logic [4:0]             rs2Addr_Out,
    output logic                   rs2Enable_Out,
    output logic [31:0]            imm_Out,
    output logic                   isMulDiv_Out,
    output logic                   illegal_Out,
    output logic [$clog2(DEPTH):0] count_Out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] INSTR_TYPE_NONE = 3'd0;
    localparam logic [2:0] INSTR_TYPE_R    = 3'd1;
    localparam logic [2:0] INSTR_TYPE_I    = 3'd2;
    localparam logic [2:0] INSTR_TYPE_S    = 3'd3;
    localparam logic [2:0] INSTR_TYPE_B    = 3'd4;
    localparam logic [2:0] INSTR_TYPE_U    = 3'd5;
    localparam logic [2:0] INSTR_TYPE_J    = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]   r_instrMem [DEPTH];
    logic [31:0]   r_pcMem    [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic        w_push;
    logic        w_load;
    logic [31:0] w_instr;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_type;
    logic        w_rdEn;
    logic        w_rs1En;
    logic        w_rs2En;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_mulDiv;

    assign instrReady_Out = (r_count < CW'(DEPTH));
    assign w_push         = instrValid_In && instrReady_Out;
    assign w_load         = (r_count != '0) && (!decValid_Out || decReady_In);
    assign count_Out      = r_count;

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk_In) begin
        if (w_push && !flush_In) begin
            r_instrMem[r_wrPtr] <= instr_In;
            r_pcMem[r_wrPtr]    <= pc_In;
        end
    end

    always_ff @(posedge clk_In or posedge rst_In) begin
        if (rst_In) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_In) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_load) r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_load);
        end
    end

    assign w_instr = r_instrMem[r_rdPtr];
    assign w_opc   = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];

    always_comb begin
        w_type    = INSTR_TYPE_NONE;
        w_rdEn    = 1'b0;
        w_rs1En   = 1'b0;
        w_rs2En   = 1'b0;
        w_imm     = '0;
        w_illegal = 1'b0;
        w_mulDiv  = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_type  = INSTR_TYPE_R;
                w_rdEn  = 1'b1;
                w_rs1En = 1'b1;
                w_rs2En = 1'b1;
                if (ENABLE_M && w_f7 == 7'b0000001)
                    w_mulDiv = 1'b1;
                else if (!(w_f7 == 7'b0000000 ||
                           (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_illegal = 1'b1;
            end
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                w_type  = INSTR_TYPE_I;
                w_rdEn  = 1'b1;
                w_rs1En = 1'b1;
                w_imm   = {{20{w_instr[31]}}, w_instr[31:20]};
                if (w_opc == OPC_LOAD)
                    w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
                else if (w_opc == OPC_JALR)
                    w_illegal = (w_f3 != 3'b000);
                else if (w_f3 == 3'b001)
                    w_illegal = (w_f7 != 7'b0000000);
                else if (w_f3 == 3'b101)
                    w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
            end
            OPC_STORE: begin
                w_type    = INSTR_TYPE_S;
                w_rs1En   = 1'b1;
                w_rs2En   = 1'b1;
                w_imm     = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_illegal = (w_f3 > 3'b010);
            end
            OPC_BRANCH: begin
                w_type    = INSTR_TYPE_B;
                w_rs1En   = 1'b1;
                w_rs2En   = 1'b1;
                w_imm     = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                             w_instr[30:25], w_instr[11:8], 1'b0};
                w_illegal = (w_f3[2:1] == 2'b01);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_type = INSTR_TYPE_U;
                w_rdEn = 1'b1;
                w_imm  = {w_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_type = INSTR_TYPE_J;
                w_rdEn = 1'b1;
                w_imm  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                          w_instr[20], w_instr[30:21], 1'b0};
            end
            OPC_SYSTEM, OPC_MISC: w_type = INSTR_TYPE_NONE;
            default:              w_illegal = 1'b1;
        endcase
    end

    // Output stage: load on a free/draining slot, drop valid on a consume with nothing behind it.
    always_ff @(posedge clk_In or posedge rst_In) begin
        if (rst_In) begin
            decValid_Out  <= 1'b0;
            pc_Out        <= '0;
            instrType_Out <= '0;
            funct3_Out    <= '0;
            rdAddr_Out    <= '0;
            rs1Addr_Out   <= '0;
            rs1Enable_Out <= 1'b0;
            rs2Addr_Out   <= '0;
            rs2Enable_Out <= 1'b0;
            imm_Out       <= '0;
            isMulDiv_Out  <= 1'b0;
            illegal_Out   <= 1'b0;
        end else if (flush_In) begin
            decValid_Out <= 1'b0;
        end else if (w_load) begin
            decValid_Out  <= 1'b1;
            pc_Out        <= r_pcMem[r_rdPtr];
            instrType_Out <= w_type;
            funct3_Out    <= w_f3;
            rdAddr_Out    <= w_rdEn  ? w_instr[11:7]  : 5'd0;
            rs1Addr_Out   <= w_rs1En ? w_instr[19:15] : 5'd0;
            rs1Enable_Out <= w_rs1En;
            rs2Addr_Out   <= w_rs2En ? w_instr[24:20] : 5'd0;
            rs2Enable_Out <= w_rs2En;
            imm_Out       <= w_imm;
            isMulDiv_Out  <= w_mulDiv;
            illegal_Out   <= w_illegal;
        end else if (decValid_Out && decReady_In) begin
            decValid_Out <= 1'b0;
        end
    end
endmodule
